// File: rtl/mpeg_pkg.sv
// Shared types and widths for the MPEG byte input path.
// Holds no logic, only constants and the byte type used by the buffer and its RAM.
package mpeg_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 32;

    typedef logic [BYTE_W-1:0] mpeg_byte_t;

endpackage

// File: rtl/mpeg_byte_ram.sv
// Simple dual-port byte RAM: one write port and one read port. The read is registered (1 cycle).
// No backpressure. rd_data holds its value unless rd_en is high, so it can act as an output register.
module mpeg_byte_ram
    import mpeg_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  mpeg_byte_t    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output mpeg_byte_t    rd_data
);

    mpeg_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset; the array stays reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!srst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mpeg_in_buffer.sv
// Elastic byte buffer with a FWFT valid/ready output. A write reaches out_valid 2 edges later; one byte/cycle sustained.
// There is no input backpressure: the source pauses on prog_full, and a write while full is dropped and flagged.
module mpeg_in_buffer
    import mpeg_pkg::*;
#(
    parameter int DEPTH            = 1024,
    parameter int PROG_FULL_THRESH = 768,
    parameter int AW               = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  mpeg_byte_t       in_data,
    input  logic             in_en,
    input  logic             stream_end,
    output logic             prog_full,
    output logic             full,
    output logic             overflow,
    output mpeg_byte_t       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             eos_done,
    output logic [AW:0]      level,
    output logic [CNT_W-1:0] in_cnt,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [AW:0] DEPTH_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_LVL = (AW+1)'(PROG_FULL_THRESH);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   ram_cnt;
    logic          eos_seen;
    logic          wr_fire;
    logic          acc;
    logic          load;

    assign full      = (level == DEPTH_LVL);
    assign prog_full = (level >= THRESH_LVL);
    assign wr_fire   = in_en & ~full;
    assign acc       = out_valid & out_ready;
    // Refill the output stage when it is empty or is being emptied this cycle.
    assign load      = (~out_valid | out_ready) & (ram_cnt != '0);
    assign out_last  = out_valid & eos_seen & (level == (AW+1)'(1));

    // The RAM read register is the output data register; out_valid qualifies it.
    mpeg_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .srst    (srst),
        .wr_en   (wr_fire),
        .wr_addr (wp),
        .wr_data (in_data),
        .rd_en   (load),
        .rd_addr (rp),
        .rd_data (out_data)
    );

    always_ff @(posedge clk) begin
        if (!srst) begin
            wp        <= '0;
            rp        <= '0;
            ram_cnt   <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            overflow  <= 1'b0;
            eos_seen  <= 1'b0;
            eos_done  <= 1'b0;
        end else begin
            if (wr_fire) begin
                wp     <= wp + 1'b1;
                in_cnt <= in_cnt + 32'd1;
            end
            if (load) begin
                rp <= rp + 1'b1;
            end
            if (acc) begin
                out_cnt <= out_cnt + 32'd1;
            end

            unique case ({wr_fire, load})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ;
            endcase

            unique case ({wr_fire, acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase

            out_valid <= load | (out_valid & ~out_ready);

            if (in_en & full) begin
                overflow <= 1'b1;
            end

            if (stream_end) begin
                eos_seen <= 1'b1;
            end

            // An empty buffer at end of stream has nothing left to deliver.
            if ((acc & out_last) |
                ((eos_seen | stream_end) & (level == '0) & ~in_en)) begin
                eos_done <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_level_bound : assert property (@(posedge clk) disable iff (!srst) level <= DEPTH_LVL);
    a_data_stable : assert property (@(posedge clk) disable iff (!srst)
                                     (out_valid & ~out_ready) |=> $stable(out_data));
`endif

endmodule

// File: tb/tb_mpeg_in_buffer.sv
// Directed bench for mpeg_in_buffer at DEPTH=16, THRESH=12: a vector table, then scoreboarded multi-cycle sequences.
module tb_mpeg_in_buffer;

    localparam int DEPTH  = 16;
    localparam int THRESH = 12;

    logic        clk;
    logic        srst;
    logic [7:0]  in_data;
    logic        in_en;
    logic        stream_end;
    logic        prog_full;
    logic        full;
    logic        overflow;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        eos_done;
    logic [4:0]  level;
    logic [31:0] in_cnt;
    logic [31:0] out_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    int         mlevel;
    int         m_in;
    int         m_out;
    logic       movf;

    mpeg_in_buffer #(
        .DEPTH            (DEPTH),
        .PROG_FULL_THRESH (THRESH)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .in_data    (in_data),
        .in_en      (in_en),
        .stream_end (stream_end),
        .prog_full  (prog_full),
        .full       (full),
        .overflow   (overflow),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .eos_done   (eos_done),
        .level      (level),
        .in_cnt     (in_cnt),
        .out_cnt    (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [7:0]  d;
        logic        rdy;
        logic [4:0]  lvl;
        logic        vld;
        logic [7:0]  dat;
        logic [31:0] icnt;
        logic [31:0] ocnt;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        srst       = 1'b0;
        in_en      = 1'b0;
        in_data    = 8'h00;
        stream_end = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk); #1;
        srst   = 1'b1;
        q.delete();
        mlevel = 0;
        m_in   = 0;
        m_out  = 0;
        movf   = 1'b0;
    endtask

    // One cycle against the model: pops on accept, pushes on a non-dropped write.
    task automatic step(input logic en, input logic [7:0] d, input logic rdy, input logic se);
        logic acc;
        logic wr;
        acc = out_valid & rdy;
        if (acc) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(q.pop_front()));
            end
            m_out++;
        end
        wr = en & (mlevel != DEPTH);
        if (en && !wr) movf = 1'b1;
        if (wr) begin
            q.push_back(d);
            m_in++;
        end
        mlevel = mlevel + int'(wr) - int'(acc);
        in_en      = en;
        in_data    = d;
        out_ready  = rdy;
        stream_end = se;
        @(posedge clk); #1;
        chk("level", 32'(level), 32'(mlevel));
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 8'h00, 32'd1, 32'd0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b1, 8'h11, 32'd2, 32'd0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b1, 8'h11, 32'd2, 32'd0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h22, 32'd2, 32'd1};
        tbl[4] = '{1'b1, 8'h33, 1'b1, 5'd1, 1'b0, 8'h00, 32'd3, 32'd2};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h33, 32'd3, 32'd2};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 32'd3, 32'd3};

        // Reset held with random writes: everything stays at zero.
        srst       = 1'b0;
        stream_end = 1'b0;
        out_ready  = 1'b0;
        in_data    = 8'h00;
        in_en      = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_en   = 1'($urandom_range(0, 1));
            in_data = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            chk("rst_level",    32'(level),     32'd0);
            chk("rst_valid",    32'(out_valid), 32'd0);
            chk("rst_data",     32'(out_data),  32'd0);
            chk("rst_last",     32'(out_last),  32'd0);
            chk("rst_full",     32'(full),      32'd0);
            chk("rst_pfull",    32'(prog_full), 32'd0);
            chk("rst_overflow", 32'(overflow),  32'd0);
            chk("rst_eos_done", 32'(eos_done),  32'd0);
            chk("rst_in_cnt",   in_cnt,         32'd0);
            chk("rst_out_cnt",  out_cnt,        32'd0);
        end
        srst  = 1'b1;
        in_en = 1'b0;

        // Vector table: prefetch latency, stall, accept, write+accept.
        for (int v = 0; v < 7; v++) begin
            in_en     = tbl[v].en;
            in_data   = tbl[v].d;
            out_ready = tbl[v].rdy;
            @(posedge clk); #1;
            chk("tbl_level", 32'(level),     32'(tbl[v].lvl));
            chk("tbl_valid", 32'(out_valid), 32'(tbl[v].vld));
            if (tbl[v].vld) chk("tbl_data", 32'(out_data), 32'(tbl[v].dat));
            chk("tbl_in_cnt",  in_cnt,  tbl[v].icnt);
            chk("tbl_out_cnt", out_cnt, tbl[v].ocnt);
        end

        // Stream 1000 bytes with the consumer always ready.
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            if (i == 0) chk("first_valid_early", 32'(out_valid), 32'd0);
            if (i == 1) chk("first_valid",       32'(out_valid), 32'd1);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_drained", 32'(q.size()), 32'd0);
        chk("stream_in_cnt",  in_cnt,  32'd1000);
        chk("stream_out_cnt", out_cnt, 32'd1000);

        // Fill past full with the consumer stalled.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 8'(k - 1), 1'b0, 1'b0);
            chk("fill_pfull", 32'(prog_full), 32'(k >= THRESH));
            chk("fill_full",  32'(full),      32'(k >= DEPTH));
        end
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_in_cnt",   in_cnt,        32'd16);
        chk("fill_level",    32'(level),    32'd16);
        // Write and accept while full: the write is dropped.
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_wr_acc_in_cnt", in_cnt, 32'd16);
        for (int k = 0; k < 40 && q.size() != 0; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fill_drained",  32'(q.size()),  32'd0);
        chk("fill_out_cnt",  out_cnt,        32'd16);
        chk("fill_valid_end", 32'(out_valid), 32'd0);

        // Random traffic across pointer wrap.
        do_reset();
        for (int k = 0; k < 100; k++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            chk("wrap_level_max", 32'(level <= 5'd16), 32'd1);
        end
        chk("wrap_overflow", 32'(overflow), 32'(movf));
        for (int k = 0; k < 20; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_drained", 32'(q.size()), 32'd0);
        chk("wrap_in_cnt",  in_cnt,  32'(m_in));
        chk("wrap_out_cnt", out_cnt, 32'(m_out));

        // End of stream after three bytes.
        do_reset();
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("eos_last_0", 32'(out_last), 32'd0);
        chk("eos_done_0", 32'(eos_done), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("eos_last_1", 32'(out_last), 32'd0);
        chk("eos_data_1", 32'(out_data), 32'hA2);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("eos_last_2", 32'(out_last), 32'd1);
        chk("eos_data_2", 32'(out_data), 32'hA3);
        chk("eos_done_2", 32'(eos_done), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("eos_done_3",  32'(eos_done),  32'd1);
        chk("eos_last_3",  32'(out_last),  32'd0);
        chk("eos_valid_3", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("eos_done_4", 32'(eos_done), 32'd1);

        // End of stream on an empty buffer.
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("eos_empty_done", 32'(eos_done), 32'd1);
        chk("eos_empty_last", 32'(out_last), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("eos_empty_last2", 32'(out_last), 32'd0);
        chk("eos_empty_done2", 32'(eos_done), 32'd1);

        // Reset in the middle of a stalled stream.
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        do_reset();
        chk("mid_level",  32'(level),     32'd0);
        chk("mid_valid",  32'(out_valid), 32'd0);
        chk("mid_data",   32'(out_data),  32'd0);
        chk("mid_in_cnt", in_cnt,         32'd0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        chk("mid_first", 32'(out_data), 32'hAA);
        for (int k = 0; k < 10 && q.size() != 0; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("mid_drained", 32'(q.size()), 32'd0);
        chk("mid_out_cnt", out_cnt, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mpeg_in_buffer.md
# mpeg_in_buffer

Byte-wide elastic buffer between the MPEG byte source and the `bhargava` decoder input. Accepts bytes with an enable-only strobe. Raises a programmable-full flag that the source uses to pause. Presents bytes to the decoder as a first-word-fall-through valid/ready stream, and tags the final byte once end-of-stream has been signalled.

## Interface

**Parameters**
- `DEPTH`, default 1024: storage in bytes; must be a power of 2, ≥ 4.
- `PROG_FULL_THRESH`, default 768: `prog_full` asserts when level ≥ this value; range 1..DEPTH.
- `AW`, default $clog2(DEPTH): address width; derived, do not override.

**Ports**
- `clk` in 1: clock.
- `srst` in 1: reset, synchronous, active-low.
- `in_data` in 8: input byte.
- `in_en` in 1: `in_data` valid this cycle; no back-pressure.
- `stream_end` in 1: level signal; once high, no further `in_en` follows. Latched.
- `prog_full` out 1: level ≥ PROG_FULL_THRESH.
- `full` out 1: level == DEPTH.
- `overflow` out 1: sticky; a byte was dropped.
- `out_data` out 8: output byte.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts when `out_valid & out_ready`.
- `out_last` out 1: qualifies `out_data` as the final byte of the stream.
- `eos_done` out 1: sticky; the final byte has been accepted downstream.
- `level` out AW+1: bytes stored, including the output register.
- `in_cnt` out 32: bytes written.
- `out_cnt` out 32: bytes accepted downstream.

## Operation

- **Storage:** circular RAM with write pointer `wp` and read pointer `rp`, each AW bits, wrapping modulo DEPTH, plus an output register (FWFT).
- **Write:** `in_en & ~full` stores `in_data` and increments `in_cnt`.
  - `in_en & full` drops the byte and sets `overflow`. `in_cnt` does not change.
- **Prefetch:** when the output register is empty (or is being accepted this cycle) and the RAM is non-empty, the head byte loads into the output register and `out_valid` is set.
- **Accept:** `out_valid & out_ready` increments `out_cnt`.
- **Level:** `level` = RAM occupancy + `out_valid`.
  - +1 on write; −1 on accept.
  - Simultaneous write and accept leaves `level` unchanged.
- **Flags:** `full` and `prog_full` are decoded from the registered `level`.
- **End of stream:** `stream_end` is latched into `eos_seen`.
  - `out_last = out_valid & eos_seen & (level == 1)`.
  - Accepting a byte while `out_last` is high sets `eos_done`.
  - If `stream_end` arrives with `level == 0`, `eos_done` sets on the next edge and `out_last` never asserts.
- **Reset mid-operation:** `srst` low discards all contents, pointers, counters and sticky flags in the same edge. No partial output.
- **Arithmetic:** 32-bit counters wrap silently.

**Reset values:** all of the following are 0 (`level` = 0, `in_cnt` = 0, `out_cnt` = 0):
- `out_valid`, `out_last`, `out_data`
- `full`, `prog_full`, `overflow`, `eos_done`
- `level`, `in_cnt`, `out_cnt`

## Timing

- **Write to `out_valid` (empty buffer):** `in_en` sampled at edge N gives `out_valid` = 1 after edge N+1.
- **Back-to-back streaming:** with `out_ready` held high, one byte per cycle; no bubbles once primed.
- **`prog_full`:** rises after the edge on which `level` reaches PROG_FULL_THRESH. The source sees it one cycle late.
  - DEPTH − PROG_FULL_THRESH must be ≥ 2 to guarantee no overflow with the registered source of the system bench.
- **`out_data` stability:** held stable while `out_valid & ~out_ready`.
- **`full` cycle:** a write and an accept in the same cycle when `full` = 1 drops the write. `full` is evaluated on pre-edge `level`.
- **`eos_done`:** rises the edge after the final accept.

## Structure

- Shared package `mpeg_pkg`:
  - `BYTE_W` = 8
  - `CNT_W` = 32
  - typedef `mpeg_byte_t`
- One sub-module, `mpeg_byte_ram`: 1-write/1-read simple dual-port RAM, registered read, DEPTH × 8. It must infer block RAM.
- Pointer/level control, output register and EOS logic stay in `mpeg_in_buffer`.

## Test plan

- **Reset:** hold `srst` = 0 for 5 cycles with random `in_en` → all outputs 0 and `level` = 0 throughout.
- **Stream 1000 bytes:** write 0x00..0xE7 (wrapping) with `out_ready` = 1 → identical sequence out.
  - First `out_valid` appears 1 cycle after the first write.
  - `in_cnt` = `out_cnt` = 1000.
- **Fill and overflow:** DEPTH = 16, THRESH = 12, `out_ready` = 0; write 20 bytes.
  - `prog_full` rises after write 12; `full` after write 16.
  - `overflow` = 1, `in_cnt` = 16, `level` = 16.
  - Draining then yields bytes 0..15 in order.
- **Pointer wrap:** DEPTH = 16; 100 cycles of random `in_en`/`out_ready` at 50% → output matches a scoreboard, `level` never exceeds 16, no `overflow`.
- **End of stream:** write 3 bytes, assert `stream_end`, then drain.
  - `out_last` is high only with the 3rd byte.
  - `eos_done` = 1 one cycle after its accept.
  - Variant with `stream_end` at `level` = 0 → `eos_done` after 1 edge, `out_last` never asserts.
- **Mid-stream reset:** pull `srst` low with `level` = 7 and `out_valid` = 1 → next cycle `level` = 0, `out_valid` = 0.
  - Subsequent writes of 0xAA, 0xBB emerge in order.
